// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle MIPS control unit. Each instruction is sequenced through
// fetch, decode, execute, memory and write-back states, and the shared ALU
// and memory datapath is driven one step per clock. Memory accesses wait on
// MemReady. An optional watchdog bounds each wait, and an illegal opcode or
// a stuck access parks the FSM in a sticky FAULT state until reset.

module multicycle_control #(
    parameter int ALUOP_W = 3,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OP,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               Jal,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               PCWrite,
    output logic               InstrDone,
    output logic               Fault
);

    // Opcode field values
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    // ALU function codes
    localparam logic [2:0] ALU_R    = 3'b111;
    localparam logic [2:0] ALU_ADDI = 3'b110;
    localparam logic [2:0] ALU_ORI  = 3'b101;
    localparam logic [2:0] ALU_LUI  = 3'b100;
    localparam logic [2:0] ALU_ADD  = 3'b011;
    localparam logic [2:0] ALU_ANDI = 3'b001;
    localparam logic [2:0] ALU_CMP  = 3'b000;

    // Datapath select encodings
    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;
    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JMP  = 2'b10;

    // Watchdog: the wait that would bring the count up to TIMEOUT is the
    // last one tolerated, so the compare value is TIMEOUT-1.
    localparam bit             LP_WD_EN    = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC_R,
        EXEC_I,
        ALUWB,
        BRANCH,
        JUMP,
        FAULT
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [5:0]       r_op;
    logic [CNT_W-1:0] r_waitCnt;

    logic             w_waitState;
    logic             w_timeout;

    logic             w_iorD;
    logic             w_memRead;
    logic             w_memWrite;
    logic             w_irWrite;
    logic             w_regDst;
    logic             w_memtoReg;
    logic             w_regWrite;
    logic             w_jal;
    logic             w_aluSrcA;
    logic [1:0]       w_aluSrcB;
    logic [2:0]       w_aluOp;
    logic [1:0]       w_pcSource;
    logic             w_pcWrite;
    logic             w_instrDone;
    logic             w_fault;

    assign w_waitState = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
    assign w_timeout   = LP_WD_EN && w_waitState && !MemReady && (r_waitCnt == LP_CNT_LAST);

    // State register; reset returns to FETCH from anywhere, including FAULT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Opcode is captured while in DECODE so later states can still see it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op <= '0;
        end else if (r_state == DECODE) begin
            r_op <= OP;
        end
    end

    // Wait counter: restarts on every state change, counts stalled cycles in memory states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_waitCnt <= '0;
        end else if (w_nextState != r_state) begin
            r_waitCnt <= '0;
        end else if (LP_WD_EN && w_waitState && !MemReady) begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
        end
    end

    // Next-state logic and Moore output decode, with MemReady/Zero gating where needed
    always_comb begin
        w_nextState = r_state;
        w_iorD      = 1'b0;
        w_memRead   = 1'b0;
        w_memWrite  = 1'b0;
        w_irWrite   = 1'b0;
        w_regDst    = 1'b0;
        w_memtoReg  = 1'b0;
        w_regWrite  = 1'b0;
        w_jal       = 1'b0;
        w_aluSrcA   = 1'b0;
        w_aluSrcB   = SRCB_RT;
        w_aluOp     = ALU_CMP;
        w_pcSource  = PCSRC_ALU;
        w_pcWrite   = 1'b0;
        w_instrDone = 1'b0;
        w_fault     = 1'b0;

        case (r_state)
            FETCH: begin
                w_memRead  = 1'b1;
                w_aluSrcB  = SRCB_FOUR;
                w_aluOp    = ALU_ADD;
                w_pcSource = PCSRC_ALU;
                w_irWrite  = MemReady;
                w_pcWrite  = MemReady;
                if (MemReady) begin
                    w_nextState = DECODE;
                end else if (w_timeout) begin
                    w_nextState = FAULT;
                end
            end

            DECODE: begin
                w_aluSrcB = SRCB_SHIMM;
                w_aluOp   = ALU_ADD;
                case (OP)
                    OP_LW, OP_SW:                     w_nextState = MEMADR;
                    OP_R:                             w_nextState = EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_nextState = EXEC_I;
                    OP_BEQ, OP_BNE:                   w_nextState = BRANCH;
                    OP_J, OP_JAL:                     w_nextState = JUMP;
                    default:                          w_nextState = FAULT;
                endcase
            end

            MEMADR: begin
                w_aluSrcA   = 1'b1;
                w_aluSrcB   = SRCB_IMM;
                w_aluOp     = ALU_ADD;
                w_nextState = (r_op == OP_LW) ? MEMRD : MEMWR;
            end

            MEMRD: begin
                w_memRead = 1'b1;
                w_iorD    = 1'b1;
                if (MemReady) begin
                    w_nextState = MEMWB;
                end else if (w_timeout) begin
                    w_nextState = FAULT;
                end
            end

            MEMWB: begin
                w_regWrite  = 1'b1;
                w_memtoReg  = 1'b1;
                w_instrDone = 1'b1;
                w_nextState = FETCH;
            end

            MEMWR: begin
                w_memWrite  = 1'b1;
                w_iorD      = 1'b1;
                w_instrDone = MemReady;
                if (MemReady) begin
                    w_nextState = FETCH;
                end else if (w_timeout) begin
                    w_nextState = FAULT;
                end
            end

            EXEC_R: begin
                w_aluSrcA   = 1'b1;
                w_aluSrcB   = SRCB_RT;
                w_aluOp     = ALU_R;
                w_nextState = ALUWB;
            end

            EXEC_I: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = SRCB_IMM;
                case (r_op)
                    OP_ANDI: w_aluOp = ALU_ANDI;
                    OP_ORI:  w_aluOp = ALU_ORI;
                    OP_LUI:  w_aluOp = ALU_LUI;
                    default: w_aluOp = ALU_ADDI;
                endcase
                w_nextState = ALUWB;
            end

            ALUWB: begin
                w_regWrite  = 1'b1;
                w_regDst    = (r_op == OP_R);
                w_instrDone = 1'b1;
                w_nextState = FETCH;
            end

            BRANCH: begin
                w_aluSrcA   = 1'b1;
                w_aluSrcB   = SRCB_RT;
                w_aluOp     = ALU_CMP;
                w_pcSource  = PCSRC_OUT;
                w_pcWrite   = (r_op == OP_BNE) ? !Zero : Zero;
                w_instrDone = 1'b1;
                w_nextState = FETCH;
            end

            JUMP: begin
                w_pcSource  = PCSRC_JMP;
                w_pcWrite   = 1'b1;
                w_instrDone = 1'b1;
                w_jal       = (r_op == OP_JAL);
                w_regWrite  = (r_op == OP_JAL);
                w_nextState = FETCH;
            end

            FAULT: begin
                w_fault     = 1'b1;
                w_nextState = FAULT;
            end

            default: begin
                w_nextState = FAULT;
            end
        endcase
    end

    // Every output is forced low while reset is held so no strobe outlives it
    assign IorD      = w_iorD      & ~reset;
    assign MemRead   = w_memRead   & ~reset;
    assign MemWrite  = w_memWrite  & ~reset;
    assign IRWrite   = w_irWrite   & ~reset;
    assign RegDst    = w_regDst    & ~reset;
    assign MemtoReg  = w_memtoReg  & ~reset;
    assign RegWrite  = w_regWrite  & ~reset;
    assign Jal       = w_jal       & ~reset;
    assign ALUSrcA   = w_aluSrcA   & ~reset;
    assign ALUSrcB   = reset ? 2'b00 : w_aluSrcB;
    assign ALUOp     = reset ? '0 : ALUOP_W'(w_aluOp);
    assign PCSource  = reset ? 2'b00 : w_pcSource;
    assign PCWrite   = w_pcWrite   & ~reset;
    assign InstrDone = w_instrDone & ~reset;
    assign Fault     = w_fault     & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Table-driven bench with a scoreboard queue. Two instances share inputs:
// dut5 (TIMEOUT=5, ALUOP_W=4) and dut0 (defaults, watchdog off).

`timescale 1ns/1ps

module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OP;
    logic       Zero;
    logic       MemReady;

    logic       IorD5, MemRead5, MemWrite5, IRWrite5, RegDst5, MemtoReg5, RegWrite5, Jal5, ALUSrcA5;
    logic [1:0] ALUSrcB5, PCSource5;
    logic [3:0] ALUOp5;
    logic       PCWrite5, InstrDone5, Fault5;

    logic       IorD0, MemRead0, MemWrite0, IRWrite0, RegDst0, MemtoReg0, RegWrite0, Jal0, ALUSrcA0;
    logic [1:0] ALUSrcB0, PCSource0;
    logic [2:0] ALUOp0;
    logic       PCWrite0, InstrDone0, Fault0;

    multicycle_control #(.ALUOP_W(4), .TIMEOUT(5), .CNT_W(8)) dut5 (
        .clk(clk), .reset(reset), .OP(OP), .Zero(Zero), .MemReady(MemReady),
        .IorD(IorD5), .MemRead(MemRead5), .MemWrite(MemWrite5), .IRWrite(IRWrite5),
        .RegDst(RegDst5), .MemtoReg(MemtoReg5), .RegWrite(RegWrite5), .Jal(Jal5),
        .ALUSrcA(ALUSrcA5), .ALUSrcB(ALUSrcB5), .ALUOp(ALUOp5), .PCSource(PCSource5),
        .PCWrite(PCWrite5), .InstrDone(InstrDone5), .Fault(Fault5)
    );

    multicycle_control dut0 (
        .clk(clk), .reset(reset), .OP(OP), .Zero(Zero), .MemReady(MemReady),
        .IorD(IorD0), .MemRead(MemRead0), .MemWrite(MemWrite0), .IRWrite(IRWrite0),
        .RegDst(RegDst0), .MemtoReg(MemtoReg0), .RegWrite(RegWrite0), .Jal(Jal0),
        .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0), .ALUOp(ALUOp0), .PCSource(PCSource0),
        .PCWrite(PCWrite0), .InstrDone(InstrDone0), .Fault(Fault0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memtoReg;
        logic       regWrite;
        logic       jal;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [3:0] aluOp;
        logic [1:0] pcSource;
        logic       pcWrite;
        logic       instrDone;
        logic       fault;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic       zero;
        logic       mr;
        outs_t      e5;
        outs_t      e0;
    } vec_t;

    typedef struct {
        int    id;
        outs_t e5;
        outs_t e0;
    } sb_t;

    vec_t  vecs[$];
    sb_t   sbq[$];
    int    checks = 0;
    int    passed = 0;
    int    stepId = 0;

    outs_t ZERO, FETCH_W, FETCH_R, DECODE_O, MEMADR_O, MEMRD_O, MEMWB_O, MEMWR_W, MEMWR_R;
    outs_t EXECR_O, ALUWB_R, ALUWB_I, BR_T, BR_N, JUMP_O, JAL_O, FAULT_O;

    function automatic outs_t pack5();
        outs_t o;
        o = '{IorD5, MemRead5, MemWrite5, IRWrite5, RegDst5, MemtoReg5, RegWrite5, Jal5,
              ALUSrcA5, ALUSrcB5, ALUOp5, PCSource5, PCWrite5, InstrDone5, Fault5};
        return o;
    endfunction

    function automatic outs_t pack0();
        outs_t o;
        o = '{IorD0, MemRead0, MemWrite0, IRWrite0, RegDst0, MemtoReg0, RegWrite0, Jal0,
              ALUSrcA0, ALUSrcB0, {1'b0, ALUOp0}, PCSource0, PCWrite0, InstrDone0, Fault0};
        return o;
    endfunction

    function automatic outs_t execI(input logic [3:0] code);
        outs_t o;
        o         = '0;
        o.aluSrcA = 1'b1;
        o.aluSrcB = 2'b10;
        o.aluOp   = code;
        return o;
    endfunction

    // Expected per-state output patterns, written out field by field
    task automatic initExpect();
        ZERO = '0;
        FETCH_W = '0; FETCH_W.memRead = 1'b1; FETCH_W.aluSrcB = 2'b01; FETCH_W.aluOp = 4'b0011;
        FETCH_R = FETCH_W; FETCH_R.irWrite = 1'b1; FETCH_R.pcWrite = 1'b1;
        DECODE_O = '0; DECODE_O.aluSrcB = 2'b11; DECODE_O.aluOp = 4'b0011;
        MEMADR_O = '0; MEMADR_O.aluSrcA = 1'b1; MEMADR_O.aluSrcB = 2'b10; MEMADR_O.aluOp = 4'b0011;
        MEMRD_O = '0; MEMRD_O.memRead = 1'b1; MEMRD_O.iorD = 1'b1;
        MEMWB_O = '0; MEMWB_O.regWrite = 1'b1; MEMWB_O.memtoReg = 1'b1; MEMWB_O.instrDone = 1'b1;
        MEMWR_W = '0; MEMWR_W.memWrite = 1'b1; MEMWR_W.iorD = 1'b1;
        MEMWR_R = MEMWR_W; MEMWR_R.instrDone = 1'b1;
        EXECR_O = '0; EXECR_O.aluSrcA = 1'b1; EXECR_O.aluOp = 4'b0111;
        ALUWB_I = '0; ALUWB_I.regWrite = 1'b1; ALUWB_I.instrDone = 1'b1;
        ALUWB_R = ALUWB_I; ALUWB_R.regDst = 1'b1;
        BR_N = '0; BR_N.aluSrcA = 1'b1; BR_N.pcSource = 2'b01; BR_N.instrDone = 1'b1;
        BR_T = BR_N; BR_T.pcWrite = 1'b1;
        JUMP_O = '0; JUMP_O.pcSource = 2'b10; JUMP_O.pcWrite = 1'b1; JUMP_O.instrDone = 1'b1;
        JAL_O = JUMP_O; JAL_O.jal = 1'b1; JAL_O.regWrite = 1'b1;
        FAULT_O = '0; FAULT_O.fault = 1'b1;
    endtask

    task automatic compareOuts(input string tag, input int id, input outs_t act, input outs_t exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s step %0d: got %h expected %h", tag, id, act, exp);
    endtask

    task automatic addRow(input logic [5:0] op, input logic z, input logic mr, input outs_t e5, input outs_t e0);
        vec_t v;
        v.op = op; v.zero = z; v.mr = mr; v.e5 = e5; v.e0 = e0;
        vecs.push_back(v);
    endtask

    task automatic addRow1(input logic [5:0] op, input logic z, input logic mr, input outs_t e);
        addRow(op, z, mr, e, e);
    endtask

    // Drive one cycle of inputs and queue what both instances should show
    task automatic applyStimulus(input logic [5:0] op, input logic z, input logic mr, input outs_t e5, input outs_t e0);
        sb_t s;
        OP = op; Zero = z; MemReady = mr;
        s.id = stepId; s.e5 = e5; s.e0 = e0;
        stepId++;
        sbq.push_back(s);
    endtask

    // Sample at the falling edge, compare against the oldest queued entry, realign after the rising edge
    task automatic checkOutput();
        sb_t s;
        @(negedge clk);
        if (sbq.size() == 0) begin
            checks++;
            $display("[TB] FAIL scoreboard step %0d: got empty queue expected an entry", stepId);
        end else begin
            s = sbq.pop_front();
            compareOuts("dut5", s.id, pack5(), s.e5);
            compareOuts("dut0", s.id, pack0(), s.e0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runStep(input logic [5:0] op, input logic z, input logic mr, input outs_t e5, input outs_t e0);
        applyStimulus(op, z, mr, e5, e0);
        checkOutput();
    endtask

    task automatic checkNow(input string tag, input outs_t e5, input outs_t e0);
        compareOuts({tag, "_dut5"}, stepId, pack5(), e5);
        compareOuts({tag, "_dut0"}, stepId, pack0(), e0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got no finish expected finish before 100us");
        $fatal(1, "[TB] simulation time bound exceeded");
    end

    initial begin
        initExpect();
        OP = 6'h00; Zero = 1'b0; MemReady = 1'b0;
        reset = 1'b1;
        #2;
        checkNow("reset_state", ZERO, ZERO);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ADDI, R, ANDI, ORI, LUI with MemReady=1
        addRow1(6'h08, 0, 1, FETCH_R); addRow1(6'h08, 0, 0, DECODE_O);
        addRow1(6'h08, 0, 0, execI(4'b0110)); addRow1(6'h08, 0, 0, ALUWB_I);
        addRow1(6'h00, 0, 1, FETCH_R); addRow1(6'h00, 0, 1, DECODE_O);
        addRow1(6'h00, 0, 1, EXECR_O); addRow1(6'h00, 0, 1, ALUWB_R);
        addRow1(6'h0C, 0, 1, FETCH_R); addRow1(6'h0C, 0, 1, DECODE_O);
        addRow1(6'h0C, 0, 1, execI(4'b0001)); addRow1(6'h0C, 0, 1, ALUWB_I);
        addRow1(6'h0D, 1, 1, FETCH_R); addRow1(6'h0D, 1, 1, DECODE_O);
        addRow1(6'h0D, 1, 1, execI(4'b0101)); addRow1(6'h0D, 1, 1, ALUWB_I);
        addRow1(6'h0F, 0, 1, FETCH_R); addRow1(6'h0F, 0, 1, DECODE_O);
        addRow1(6'h0F, 0, 1, execI(4'b0100)); addRow1(6'h0F, 0, 1, ALUWB_I);
        // LW with three stalled cycles in MEMRD: eight cycles total
        addRow1(6'h23, 0, 1, FETCH_R); addRow1(6'h23, 0, 1, DECODE_O); addRow1(6'h23, 0, 1, MEMADR_O);
        for (int i = 0; i < 3; i++) addRow1(6'h23, 0, 0, MEMRD_O);
        addRow1(6'h23, 0, 1, MEMRD_O); addRow1(6'h23, 0, 1, MEMWB_O);
        // SW with one stall in FETCH and one in MEMWR
        addRow1(6'h2B, 0, 0, FETCH_W); addRow1(6'h2B, 0, 1, FETCH_R); addRow1(6'h2B, 0, 1, DECODE_O);
        addRow1(6'h2B, 0, 1, MEMADR_O); addRow1(6'h2B, 0, 0, MEMWR_W); addRow1(6'h2B, 0, 1, MEMWR_R);
        // Branches: BEQ/BNE against both Zero values
        addRow1(6'h04, 1, 1, FETCH_R); addRow1(6'h04, 1, 1, DECODE_O); addRow1(6'h04, 1, 1, BR_T);
        addRow1(6'h05, 1, 1, FETCH_R); addRow1(6'h05, 1, 1, DECODE_O); addRow1(6'h05, 1, 1, BR_N);
        addRow1(6'h04, 0, 1, FETCH_R); addRow1(6'h04, 0, 1, DECODE_O); addRow1(6'h04, 0, 1, BR_N);
        addRow1(6'h05, 0, 1, FETCH_R); addRow1(6'h05, 0, 1, DECODE_O); addRow1(6'h05, 0, 1, BR_T);
        // J and JAL
        addRow1(6'h02, 0, 1, FETCH_R); addRow1(6'h02, 0, 1, DECODE_O); addRow1(6'h02, 0, 1, JUMP_O);
        addRow1(6'h03, 0, 1, FETCH_R); addRow1(6'h03, 0, 1, DECODE_O); addRow1(6'h03, 0, 1, JAL_O);
        // LW with four waits in FETCH and four in MEMRD: each access stays under the limit
        for (int i = 0; i < 4; i++) addRow1(6'h23, 0, 0, FETCH_W);
        addRow1(6'h23, 0, 1, FETCH_R); addRow1(6'h23, 0, 1, DECODE_O); addRow1(6'h23, 0, 1, MEMADR_O);
        for (int i = 0; i < 4; i++) addRow1(6'h23, 0, 0, MEMRD_O);
        addRow1(6'h23, 0, 1, MEMRD_O); addRow1(6'h23, 0, 1, MEMWB_O);
        // Illegal opcode: FAULT is sticky whatever the inputs do
        addRow1(6'h3F, 0, 1, FETCH_R); addRow1(6'h3F, 0, 1, DECODE_O);
        for (int i = 0; i < 10; i++) addRow1(6'h08, i[0], i[1], FAULT_O);

        for (int i = 0; i < vecs.size(); i++) begin
            runStep(vecs[i].op, vecs[i].zero, vecs[i].mr, vecs[i].e5, vecs[i].e0);
        end

        // Reset out of FAULT clears it asynchronously and restarts in FETCH
        #2;
        reset = 1'b1;
        #1;
        checkNow("reset_from_fault", ZERO, ZERO);
        @(posedge clk);
        #1;
        reset = 1'b0;
        runStep(6'h08, 0, 1, FETCH_R, FETCH_R);
        runStep(6'h08, 0, 1, DECODE_O, DECODE_O);
        runStep(6'h08, 0, 1, execI(4'b0110), execI(4'b0110));
        runStep(6'h08, 0, 1, ALUWB_I, ALUWB_I);

        // Reset during a stalled store: the write strobe drops immediately
        runStep(6'h2B, 0, 1, FETCH_R, FETCH_R);
        runStep(6'h2B, 0, 1, DECODE_O, DECODE_O);
        runStep(6'h2B, 0, 1, MEMADR_O, MEMADR_O);
        runStep(6'h2B, 0, 0, MEMWR_W, MEMWR_W);
        MemReady = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checkNow("reset_mid_store", ZERO, ZERO);
        @(negedge clk);
        checkNow("reset_held", ZERO, ZERO);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // MemReady stuck low in FETCH: dut5 faults after five waits, dut0 keeps waiting
        for (int i = 0; i < 5; i++) runStep(6'h08, 0, 0, FETCH_W, FETCH_W);
        for (int i = 0; i < 3; i++) runStep(6'h08, 0, 0, FAULT_O, FETCH_W);

        reset = 1'b1;
        #2;
        checkNow("reset_after_timeout", ZERO, ZERO);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // MemReady arrives on the fifth FETCH cycle: no fault
        for (int i = 0; i < 4; i++) runStep(6'h08, 0, 0, FETCH_W, FETCH_W);
        runStep(6'h08, 0, 1, FETCH_R, FETCH_R);
        runStep(6'h08, 0, 1, DECODE_O, DECODE_O);
        runStep(6'h08, 0, 1, execI(4'b0110), execI(4'b0110));
        runStep(6'h08, 0, 1, ALUWB_I, ALUWB_I);
        runStep(6'h08, 0, 1, FETCH_R, FETCH_R);

        // Store stuck in MEMWR: dut5 faults after five waits
        runStep(6'h2B, 0, 1, DECODE_O, DECODE_O);
        runStep(6'h2B, 0, 1, MEMADR_O, MEMADR_O);
        for (int i = 0; i < 5; i++) runStep(6'h2B, 0, 0, MEMWR_W, MEMWR_W);
        for (int i = 0; i < 2; i++) runStep(6'h2B, 0, 0, FAULT_O, MEMWR_W);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle FSM control unit for the MIPS core. It replaces the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the shared-ALU / shared-memory datapath one step per clock. Memory accesses are stretched by a ready handshake, and a parametrised watchdog converts stuck accesses or illegal opcodes into a sticky fault.

## Interface
Parameters:
- ALUOP_W, 3: width of ALUOp. The low 3 bits carry the codes below; extra upper bits are driven 0.
- TIMEOUT, 0: maximum wait cycles for MemReady per access. 0 disables the watchdog.
- CNT_W, 8: width of the wait counter. Requires TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- OP  in  6  opcode field, read from the instruction register
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- IorD  out  1  memory address select (0 = PC, 1 = ALUOut)
- MemRead, MemWrite  out  1  memory strobes, held until MemReady
- IRWrite  out  1  instruction register load
- RegDst  out  1  destination register select (1 = rd)
- MemtoReg  out  1  write-back data select (1 = MDR)
- RegWrite  out  1  register file write
- Jal  out  1  force write register 31 with PC
- ALUSrcA  out  1  ALU A select (0 = PC, 1 = rs)
- ALUSrcB  out  2  ALU B select: 00 rt, 01 const 4, 10 sign-ext imm, 11 shifted imm
- ALUOp  out  ALUOP_W  ALU function code
- PCSource  out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target
- PCWrite  out  1  final PC enable, branch condition already resolved
- InstrDone  out  1  one-cycle pulse on the last cycle of each instruction
- Fault  out  1  sticky error flag

## Operation
- Opcodes: R 0x00, ADDI 0x08, ANDI 0x0C, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03.
- ALUOp codes: R 111, ADDI 110, ORI 101, LUI 100, LW/SW and PC add 011, ANDI 001, branch compare 000.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP, FAULT.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=011, PCSource=00.
  - IRWrite and PCWrite go high only in the cycle MemReady=1, then the FSM moves to DECODE. Otherwise it stays.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=011 (branch target to ALUOut). Next state by OP:
  - LW/SW to MEMADR
  - R to EXEC_R
  - ADDI/ANDI/ORI/LUI to EXEC_I
  - BEQ/BNE to BRANCH
  - J/JAL to JUMP
  - anything else to FAULT
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=011. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. On MemReady goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, InstrDone=1, then FETCH.
- MEMWR: MemWrite=1, IorD=1. On MemReady asserts InstrDone and goes to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp per opcode.
- ALUWB: RegWrite=1, MemtoReg=0, RegDst=1 if R else 0, InstrDone=1, then FETCH.
  - The opcode is needed here, so it is latched into an internal register in DECODE.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=000, PCSource=01.
  - PCWrite = Zero for BEQ, ~Zero for BNE.
  - InstrDone=1, then FETCH.
- JUMP: PCSource=10, PCWrite=1, InstrDone=1, then FETCH.
  - For JAL also Jal=1 and RegWrite=1. The old PC+4 is written to register 31 in the same cycle.
- FAULT: all strobes 0, Fault=1. The FSM stays here until reset.
- Watchdog (TIMEOUT>0):
  - The counter clears on entry to FETCH, MEMRD and MEMWR, and increments each cycle MemReady=0 in those states.
  - When the count reaches TIMEOUT with MemReady still 0, the next state is FAULT.
  - MemReady in that same cycle wins: the access completes.
- Any output not named in a state is 0 in that state.

## Timing
- Reset (async assert): state FETCH, counter 0, latched opcode 0, Fault 0.
  - While reset is high, every output is 0, MemRead included.
  - After deassertion the first clock edge is evaluated in FETCH.
- Output decode:
  - All outputs are Moore decodes of the registered state.
  - IRWrite, FETCH's PCWrite, and InstrDone in MEMWR are additionally gated combinationally by MemReady.
  - BRANCH's PCWrite is gated combinationally by Zero.
- Latency with MemReady tied to 1:
  - R, I-ALU and SW: 4 cycles
  - LW: 5 cycles
  - BEQ/BNE, J, JAL: 3 cycles
- Each cycle MemReady=0 adds one cycle to the current memory state.
- Reset mid-instruction aborts immediately: no write strobe survives the reset assertion.

## Test plan
- ADDI, OP=0x08, MemReady=1 -> states FETCH, DECODE, EXEC_I, ALUWB. ALUOp=110 in EXEC_I; RegWrite=1 and RegDst=0 in cycle 4; one InstrDone pulse.
- LW with MemReady low for 3 cycles in MEMRD -> MemRead and IorD held for 4 cycles; MEMWB writes with MemtoReg=1; total latency 8 cycles.
- BEQ with Zero=1, then BNE with Zero=1 -> PCWrite=1 and PCSource=01 in BRANCH for BEQ; PCWrite=0 for BNE; both take 3 cycles.
- JAL, OP=0x03 -> in cycle 3: Jal=1, RegWrite=1, PCWrite=1, PCSource=10.
- Illegal OP=0x3F -> FAULT after DECODE, Fault=1, all strobes 0 for 10 or more cycles. Asserting reset clears Fault and restarts in FETCH.
- TIMEOUT=5, MemReady stuck low in FETCH -> FAULT entered after 5 wait cycles, IRWrite never asserted. A second run with MemReady rising on the 5th cycle completes normally with no FAULT.
